// File: rtl/fir_tap_accumulator.sv
// Serial accumulator for one sample of NUM_TAPS tap products: sums one tap per cycle,
// scales by an arithmetic right shift, saturates to DATA_WIDTH and keeps output statistics.
module fir_tap_accumulator #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_TAPS   = 4,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned OUT_SHIFT  = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_TAPS*DATA_WIDTH-1:0] tap_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           sat_flag,
  output logic                           busy,
  input  logic                           clear_stats,
  output logic [31:0]                    sample_count,
  output logic [15:0]                    sat_count
);

  localparam int unsigned IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int unsigned EXT_W = ACC_WIDTH - DATA_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(EXT_W + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(EXT_W + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] taps_q;
  logic signed [ACC_WIDTH-1:0]         acc_q;
  logic [IDX_W-1:0]                    idx_q;

  logic                        load;
  logic                        acc_en;
  logic                        last_tap;
  logic                        deliver;
  logic [DATA_WIDTH-1:0]       tap_cur;
  logic signed [ACC_WIDTH-1:0] tap_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] scaled;
  logic                        sat_hi;
  logic                        sat_lo;
  logic [DATA_WIDTH-1:0]       result;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid)            state_d = ST_ACCUM;
      ST_ACCUM:  if (last_tap)            state_d = ST_OUTPUT;
      ST_OUTPUT: if (out_ready)           state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    load    = 1'b0;
    acc_en  = 1'b0;
    deliver = 1'b0;
    case (state_q)
      ST_IDLE:   load    = in_valid;
      ST_ACCUM:  acc_en  = 1'b1;
      ST_OUTPUT: deliver = out_ready;
      default: ;
    endcase
  end

  // Running sum, scaling and clipping of the final value
  always_comb begin
    last_tap = (idx_q == IDX_W'(NUM_TAPS - 1));
    tap_cur  = taps_q[idx_q];
    tap_ext  = {{EXT_W{tap_cur[DATA_WIDTH-1]}}, tap_cur};
    sum      = acc_q + tap_ext;
    scaled   = sum >>> OUT_SHIFT;
    sat_hi   = (scaled > SAT_MAX);
    sat_lo   = (scaled < SAT_MIN);
    if (sat_hi) begin
      result = DATA_MAX;
    end else if (sat_lo) begin
      result = DATA_MIN;
    end else begin
      result = scaled[DATA_WIDTH-1:0];
    end
  end

  // Handshake flags track the next state so they stay glitch-free registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d == ST_IDLE);
      busy      <= (state_d != ST_IDLE);
      out_valid <= (state_d == ST_OUTPUT);
    end
  end

  // Datapath: capture taps, accumulate, latch the result on the last tap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      out_data <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (load) begin
        taps_q <= tap_data;
        acc_q  <= '0;
        idx_q  <= '0;
      end
      if (acc_en) begin
        acc_q <= sum;
        idx_q <= last_tap ? '0 : idx_q + IDX_W'(1);
        if (last_tap) begin
          out_data <= result;
          sat_flag <= sat_hi | sat_lo;
        end
      end
    end
  end

  // Delivery statistics; a coincident clear overrides the increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_count <= '0;
      sat_count    <= '0;
    end else if (clear_stats) begin
      sample_count <= '0;
      sat_count    <= '0;
    end else if (deliver) begin
      sample_count <= sample_count + 32'd1;
      if (sat_flag && (sat_count != 16'hFFFF)) begin
        sat_count <= sat_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Directed bench for fir_tap_accumulator: DATA_WIDTH=16, NUM_TAPS=4, ACC_WIDTH=20,
// plus a second instance with OUT_SHIFT=2 sharing the same stimulus.
module tb_fir_tap_accumulator;

  localparam int unsigned DW = 16;
  localparam int unsigned NT = 4;
  localparam int unsigned AW = 20;

  logic          clk;
  logic          rst_n;
  logic [NT*DW-1:0] tap_data;
  logic          in_valid;
  logic          out_ready;
  logic          clear_stats;

  logic          in_ready,  in_ready_s;
  logic [DW-1:0] out_data,  out_data_s;
  logic          out_valid, out_valid_s;
  logic          sat_flag,  sat_flag_s;
  logic          busy,      busy_s;
  logic [31:0]   sample_count, sample_count_s;
  logic [15:0]   sat_count,    sat_count_s;

  int n_cmp;
  int n_fail;

  fir_tap_accumulator #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .ACC_WIDTH(AW), .OUT_SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .tap_data(tap_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .sat_flag(sat_flag),
    .busy(busy), .clear_stats(clear_stats), .sample_count(sample_count), .sat_count(sat_count)
  );

  fir_tap_accumulator #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .ACC_WIDTH(AW), .OUT_SHIFT(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .tap_data(tap_data), .in_valid(in_valid), .in_ready(in_ready_s),
    .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(out_ready), .sat_flag(sat_flag_s),
    .busy(busy_s), .clear_stats(clear_stats), .sample_count(sample_count_s), .sat_count(sat_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NT*DW-1:0] pack(input logic [DW-1:0] t0, input logic [DW-1:0] t1,
                                             input logic [DW-1:0] t2, input logic [DW-1:0] t3);
    return {t3, t2, t1, t0};
  endfunction

  // Present a sample from a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [NT*DW-1:0] taps, output bit ok);
    int n;
    tap_data = taps;
    in_valid = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 40) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
  endtask

  // Count cycles from the first post-accept cycle until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clear_stats = 1'b0; tap_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    n_cmp++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat_flag got %b want 0", sat_flag); end
    n_cmp++; if (sample_count !== 32'd0 || sat_count !== 16'd0)
      begin n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", sample_count, sat_count); end
  endtask

  task automatic test_basic();
    bit ok; int lat;
    send(pack(16'd1, 16'd2, 16'd3, 16'd4), ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_accept got 0 want 1"); end
    n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0)
      begin n_fail++; $display("FAIL basic_busy got busy=%b in_ready=%b want 1/0", busy, in_ready); end
    wait_out(lat);
    n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL basic_latency got %0d want 5", lat); end
    n_cmp++; if (out_data !== 16'd10) begin n_fail++; $display("FAIL basic_data got %h want 000a", out_data); end
    n_cmp++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL basic_sat got %b want 0", sat_flag); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop got %b want 0", out_valid); end
    n_cmp++; if (sample_count !== 32'd1) begin n_fail++; $display("FAIL basic_count got %0d want 1", sample_count); end
  endtask

  task automatic test_negative();
    bit ok; int lat;
    send(pack(-16'sd5, 16'd3, -16'sd1, 16'd1), ok);
    wait_out(lat);
    n_cmp++; if (out_data !== 16'hFFFE) begin n_fail++; $display("FAIL neg_data got %h want fffe", out_data); end
    n_cmp++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL neg_sat got %b want 0", sat_flag); end
    @(negedge clk);
    n_cmp++; if (sample_count !== 32'd2) begin n_fail++; $display("FAIL neg_count got %0d want 2", sample_count); end
  endtask

  task automatic test_saturation();
    bit ok; int lat;
    send(pack(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), ok);
    wait_out(lat);
    n_cmp++; if (out_data !== 16'h7FFF) begin n_fail++; $display("FAIL satpos_data got %h want 7fff", out_data); end
    n_cmp++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL satpos_flag got %b want 1", sat_flag); end
    @(negedge clk);
    n_cmp++; if (sat_count !== 16'd1) begin n_fail++; $display("FAIL satpos_count got %0d want 1", sat_count); end
    send(pack(16'h8000, 16'h8000, 16'h8000, 16'h8000), ok);
    wait_out(lat);
    n_cmp++; if (out_data !== 16'h8000) begin n_fail++; $display("FAIL satneg_data got %h want 8000", out_data); end
    n_cmp++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL satneg_flag got %b want 1", sat_flag); end
    @(negedge clk);
    n_cmp++; if (sat_count !== 16'd2 || sample_count !== 32'd4)
      begin n_fail++; $display("FAIL satneg_counts got %0d/%0d want 2/4", sat_count, sample_count); end
  endtask

  task automatic test_backpressure();
    bit ok; int lat; int bad;
    out_ready = 1'b0;
    send(pack(16'd2, 16'd2, 16'd2, 16'd2), ok);
    wait_out(lat);
    tap_data = pack(16'd5, 16'd5, 16'd5, 16'd5);
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 16'd8 || in_ready !== 1'b0 || sat_flag !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    n_cmp++; if (sample_count !== 32'd4) begin n_fail++; $display("FAIL bp_count_hold got %0d want 4", sample_count); end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL bp_idle got in_ready=%b busy=%b valid=%b want 1/0/0", in_ready, busy, out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_second_accept got busy=%b want 1", busy); end
    wait_out(lat);
    n_cmp++; if (out_data !== 16'd20) begin n_fail++; $display("FAIL bp_second_data got %h want 0014", out_data); end
    @(negedge clk);
    n_cmp++; if (sample_count !== 32'd6) begin n_fail++; $display("FAIL bp_count got %0d want 6", sample_count); end
  endtask

  task automatic test_reset_mid();
    bit ok; int lat; int seen;
    send(pack(16'd9, 16'd9, 16'd9, 16'd9), ok);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'd0 || sample_count !== 32'd0 || sat_count !== 16'd0)
      begin n_fail++; $display("FAIL rst_mid_outputs got busy=%b valid=%b data=%h cnt=%0d sat=%0d want all 0",
                               busy, out_valid, out_data, sample_count, sat_count); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_emit got %0d valid cycles want 0", seen); end
    send(pack(16'd1, 16'd1, 16'd1, 16'd1), ok);
    wait_out(lat);
    n_cmp++; if (out_data !== 16'd4) begin n_fail++; $display("FAIL rst_mid_next got %h want 0004", out_data); end
    @(negedge clk);
    n_cmp++; if (sample_count !== 32'd1) begin n_fail++; $display("FAIL rst_mid_count got %0d want 1", sample_count); end
  endtask

  task automatic test_shift();
    bit ok; int lat;
    send(pack(16'd7, 16'd0, 16'd0, 16'd0), ok);
    wait_out(lat);
    n_cmp++; if (out_valid_s !== 1'b1 || out_data_s !== 16'd1)
      begin n_fail++; $display("FAIL shift_pos got valid=%b data=%h want 1/0001", out_valid_s, out_data_s); end
    n_cmp++; if (out_data !== 16'd7) begin n_fail++; $display("FAIL noshift_pos got %h want 0007", out_data); end
    @(negedge clk);
    send(pack(-16'sd7, 16'd0, 16'd0, 16'd0), ok);
    wait_out(lat);
    n_cmp++; if (out_data_s !== 16'hFFFE || sat_flag_s !== 1'b0)
      begin n_fail++; $display("FAIL shift_neg got %h sat=%b want fffe/0", out_data_s, sat_flag_s); end
    n_cmp++; if (out_data !== 16'hFFF9) begin n_fail++; $display("FAIL noshift_neg got %h want fff9", out_data); end
    @(negedge clk);
  endtask

  task automatic test_clear();
    bit ok; int lat;
    out_ready = 1'b0;
    send(pack(16'd1, 16'd0, 16'd0, 16'd0), ok);
    wait_out(lat);
    n_cmp++; if (sample_count !== 32'd3) begin n_fail++; $display("FAIL clear_pre got %0d want 3", sample_count); end
    out_ready = 1'b1;
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    n_cmp++; if (sample_count !== 32'd0 || sat_count !== 16'd0 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL clear_coincident got cnt=%0d sat=%0d valid=%b want 0/0/0", sample_count, sat_count, out_valid); end
  endtask

  task automatic test_back_to_back();
    int t1; int t2; int n;
    t1 = -1; t2 = -1; n = 0;
    tap_data = pack(16'd1, 16'd1, 16'd1, 16'd1);
    in_valid = 1'b1;
    while (t2 < 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1) begin
        if (t1 < 0) t1 = n; else t2 = n;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (t2 - t1 !== 6) begin n_fail++; $display("FAIL b2b_period got %0d want 6", t2 - t1); end
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_shift();
    test_clear();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
